// File: rtl/reg_file_if.sv
// Register-file access bundle: two read addresses, one write port and the
// two combinational read results. The datapath side is the master and
// drives addresses/write controls; the register file is the slave.
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] reg1;
  logic [ADDR_WIDTH-1:0] reg2;
  logic                  reg_write;
  logic                  reg_dest;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read1;
  logic [DATA_WIDTH-1:0] read2;

  modport master (
    output reg1,
    output reg2,
    output reg_write,
    output reg_dest,
    output write_data,
    input  read1,
    input  read2
  );

  modport slave (
    input  reg1,
    input  reg2,
    input  reg_write,
    input  reg_dest,
    input  write_data,
    output read1,
    output read2
  );

endinterface

// File: rtl/reg_file.sv
// KGPRISC general-purpose register file: 2**ADDR_WIDTH entries of
// DATA_WIDTH bits, two combinational read ports and one synchronous write
// port whose destination is either register[reg1] or the link register.
// Register 0 is an ordinary storage location (no hardwired zero), and reads
// never bypass an in-flight write: new data is visible only after the edge.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LINK_REG   = 31
) (
  input  logic         clock,
  input  logic         reset,
  reg_file_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LINK_ADDR = ADDR_WIDTH'(LINK_REG);

  // Storage keeps the plain name "register" so benches and debug scripts
  // can reach it hierarchically.
  logic [DATA_WIDTH-1:0] register [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DEPTH-1:0]      wr_en;

  // Destination select: link register for calls, otherwise the reg1 field.
  always_comb begin
    wr_addr = bus.reg1;
    if (bus.reg_dest) begin
      wr_addr = LINK_ADDR;
    end
  end

  // One-hot write-enable decode; all zero when the write port is idle.
  always_comb begin
    wr_en = '0;
    if (bus.reg_write) begin
      wr_en[wr_addr] = 1'b1;
    end
  end

  // Register array update: reset clears every entry and wins over a write.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        register[i] <= '0;
      end else if (wr_en[i]) begin
        register[i] <= bus.write_data;
      end
    end
  end

  // Read muxes are purely combinational, so they follow the address with
  // zero latency and keep working while reset is held.
  always_comb begin
    bus.read1 = register[bus.reg1];
    bus.read2 = register[bus.reg2];
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, link and normal writes,
// write-disable/no-bypass, register 0, back-to-back writes, reset priority.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINK_REG(31)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.reg_write  = 1'b0;
    bus_if.reg_dest   = 1'b0;
    bus_if.write_data = '0;
    bus_if.reg1       = 5'd0;
    bus_if.reg2       = 5'd31;
    repeat (25) step();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.register[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, dut.register[i], 32'h0);
      end
    end
    n_checks++;
    if (bus_if.read1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read1: got %h expected %h", bus_if.read1, 32'h0);
    end
    n_checks++;
    if (bus_if.read2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read2: got %h expected %h", bus_if.read2, 32'h0);
    end
  endtask

  task automatic test_link_write();
    @(negedge clock);
    reset = 1'b0;
    bus_if.reg1       = 5'd1;
    bus_if.reg2       = 5'd2;
    bus_if.reg_write  = 1'b1;
    bus_if.reg_dest   = 1'b1;
    bus_if.write_data = 32'd16;
    step();
    bus_if.reg_write = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      logic [DW-1:0] exp;
      exp = (i == 31) ? 32'd16 : 32'd0;
      n_checks++;
      if (dut.register[i] !== exp) begin
        n_fail++;
        $display("FAIL link_reg%0d: got %h expected %h", i, dut.register[i], exp);
      end
    end
    n_checks++;
    if (bus_if.read1 !== 32'h0) begin
      n_fail++;
      $display("FAIL link_read1: got %h expected %h", bus_if.read1, 32'h0);
    end
    n_checks++;
    if (bus_if.read2 !== 32'h0) begin
      n_fail++;
      $display("FAIL link_read2: got %h expected %h", bus_if.read2, 32'h0);
    end
  endtask

  task automatic test_normal_write();
    @(negedge clock);
    bus_if.reg1       = 5'd3;
    bus_if.reg_dest   = 1'b0;
    bus_if.reg_write  = 1'b1;
    bus_if.write_data = 32'hFFFF_FFF0;
    step();
    bus_if.reg_write = 1'b0;
    #1;
    n_checks++;
    if ($signed(dut.register[3]) !== -32'sd16) begin
      n_fail++;
      $display("FAIL normal_reg3: got %0d expected %0d", $signed(dut.register[3]), -16);
    end
    n_checks++;
    if (bus_if.read1 !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL normal_read1: got %h expected %h", bus_if.read1, 32'hFFFF_FFF0);
    end
    n_checks++;
    if (dut.register[31] !== 32'd16) begin
      n_fail++;
      $display("FAIL normal_link_kept: got %h expected %h", dut.register[31], 32'd16);
    end
    bus_if.reg2 = 5'd3;
    #1;
    n_checks++;
    if (bus_if.read2 !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL normal_read2: got %h expected %h", bus_if.read2, 32'hFFFF_FFF0);
    end
  endtask

  task automatic test_no_bypass();
    @(negedge clock);
    bus_if.reg_write  = 1'b0;
    bus_if.reg_dest   = 1'b0;
    bus_if.write_data = 32'd99;
    bus_if.reg1       = 5'd1;
    step();
    n_checks++;
    if (dut.register[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL nowrite_reg1: got %h expected %h", dut.register[1], 32'h0);
    end
    // Idle write port with reg_dest=1 must not touch the link register.
    bus_if.reg_dest = 1'b1;
    step();
    bus_if.reg_dest = 1'b0;
    n_checks++;
    if (dut.register[31] !== 32'd16) begin
      n_fail++;
      $display("FAIL nowrite_link: got %h expected %h", dut.register[31], 32'd16);
    end
    bus_if.reg_write = 1'b1;
    #1;
    n_checks++;
    if (bus_if.read1 !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_before_edge: got %h expected %h", bus_if.read1, 32'h0);
    end
    step();
    bus_if.reg_write = 1'b0;
    #1;
    n_checks++;
    if (bus_if.read1 !== 32'd99) begin
      n_fail++;
      $display("FAIL bypass_after_edge: got %h expected %h", bus_if.read1, 32'd99);
    end
  endtask

  task automatic test_reg0_dual();
    @(negedge clock);
    bus_if.reg1       = 5'd0;
    bus_if.reg_dest   = 1'b0;
    bus_if.reg_write  = 1'b1;
    bus_if.write_data = 32'd7;
    step();
    bus_if.reg_write = 1'b0;
    bus_if.reg2      = 5'd0;
    #1;
    n_checks++;
    if (dut.register[0] !== 32'd7) begin
      n_fail++;
      $display("FAIL reg0_store: got %h expected %h", dut.register[0], 32'd7);
    end
    n_checks++;
    if (bus_if.read1 !== 32'd7) begin
      n_fail++;
      $display("FAIL reg0_read1: got %h expected %h", bus_if.read1, 32'd7);
    end
    n_checks++;
    if (bus_if.read2 !== 32'd7) begin
      n_fail++;
      $display("FAIL reg0_read2: got %h expected %h", bus_if.read2, 32'd7);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] data_tab [3];
    logic [AW-1:0] addr_tab [3];
    data_tab = '{32'hA5A5_5A5A, 32'h8000_0001, 32'h1234_5678};
    addr_tab = '{5'd10, 5'd11, 5'd12};
    // Held write of the same data across three edges.
    @(negedge clock);
    bus_if.reg1       = 5'd10;
    bus_if.reg_dest   = 1'b0;
    bus_if.reg_write  = 1'b1;
    bus_if.write_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (dut.register[10] !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL hold_write_%0d: got %h expected %h", k, dut.register[10], 32'hDEAD_BEEF);
      end
    end
    // Consecutive writes to different registers, one per cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      bus_if.reg1       = addr_tab[k];
      bus_if.write_data = data_tab[k];
    end
    step();
    bus_if.reg_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_if.reg2 = addr_tab[k];
      #1;
      n_checks++;
      if (bus_if.read2 !== data_tab[k]) begin
        n_fail++;
        $display("FAIL b2b_reg%0d: got %h expected %h", addr_tab[k], bus_if.read2, data_tab[k]);
      end
    end
    n_checks++;
    if (dut.register[9] !== 32'h0 || dut.register[13] !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_neighbours: got %h/%h expected %h", dut.register[9], dut.register[13], 32'h0);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clock);
    reset = 1'b1;
    bus_if.reg_write  = 1'b1;
    bus_if.reg_dest   = 1'b0;
    bus_if.reg1       = 5'd5;
    bus_if.write_data = 32'd55;
    step();
    n_checks++;
    if (dut.register[5] !== 32'h0) begin
      n_fail++;
      $display("FAIL rstprio_reg5: got %h expected %h", dut.register[5], 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.register[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL rstprio_reg%0d: got %h expected %h", i, dut.register[i], 32'h0);
      end
    end
    bus_if.reg1 = 5'd31;
    bus_if.reg2 = 5'd3;
    #1;
    n_checks++;
    if (bus_if.read1 !== 32'h0 || bus_if.read2 !== 32'h0) begin
      n_fail++;
      $display("FAIL rstprio_reads: got %h/%h expected %h", bus_if.read1, bus_if.read2, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    bus_if.reg_write = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus_if.reg1       = '0;
    bus_if.reg2       = '0;
    bus_if.reg_write  = 1'b0;
    bus_if.reg_dest   = 1'b0;
    bus_if.write_data = '0;
    test_reset();
    test_link_write();
    test_normal_write();
    test_no_bypass();
    test_reg0_dual();
    test_back_to_back();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
